rom_burst_arbiter: RTL and testbench
====================================

ROM_BURST_ARBITER -- requirements
Module: rom_burst_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, ROM data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of ROM words.
REQ-003 SHALL have parameter LOG_DEPTH, default $clog2(DEPTH), address and length field width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req0/req1  input  1  burst request from requester 0/1.
REQ-007 SHALL have ports addr0/addr1  input  LOG_DEPTH  burst start address from requester 0/1.
REQ-008 SHALL have ports len0/len1  input  LOG_DEPTH  burst length minus one, so 1..DEPTH words.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle acceptance pulse to requester 0/1.
REQ-010 SHALL have port rom_addr  output  LOG_DEPTH  address driven to the registered-output ROM.
REQ-011 SHALL have port rom_data  input  WIDTH  ROM read data, valid one cycle after rom_addr.
REQ-012 SHALL have port rd_data  output  WIDTH  read data to requesters, equal to rom_data.
REQ-013 SHALL have port rd_valid  output  1  rd_data holds a burst word this cycle.
REQ-014 SHALL have port rd_id  output  1  owner of the current rd_data word (0 or 1).
REQ-015 SHALL have port busy  output  1  high while in state BURST.

Function
REQ-016 SHALL implement two states: IDLE and BURST.
REQ-017 In IDLE with any reqN high, SHALL register gntN=1 for exactly one cycle, load cur_addr<=addrN, remaining<=lenN, owner<=N, and go to BURST.
REQ-018 Arbitration SHALL be round-robin: with both requests high, grant the requester not served last; with one request high, grant it regardless of history.
REQ-019 Requesters SHALL hold reqN, addrN and lenN stable until gntN; the block samples them only in the granting IDLE cycle.
REQ-020 rom_addr SHALL equal cur_addr every cycle; in IDLE it holds the last issued address.
REQ-021 Each BURST cycle SHALL issue one address: cur_addr increments modulo DEPTH, wrapping from DEPTH-1 to 0; remaining decrements.
REQ-022 BURST SHALL return to IDLE after the cycle that issues the address with remaining==0, so lenN+1 addresses are issued in consecutive cycles.
REQ-023 rd_valid and rd_id SHALL be registered copies of (state==BURST) and owner, giving one cycle latency from address issue to rd_valid.
REQ-024 If gnt occurs at the edge ending cycle T, addresses SHALL appear in T+1..T+1+len and rd_valid SHALL be high in T+2..T+2+len.
REQ-025 The earliest next grant SHALL be registered at the end of cycle T+2+len, giving exactly one rd_valid-low cycle between back-to-back bursts.
REQ-026 req changes during BURST SHALL be ignored; the burst always runs to completion.
REQ-027 gnt0 and gnt1 SHALL never be high in the same cycle, and no gnt SHALL assert during BURST.

Reset
REQ-028 On reset, the block SHALL enter IDLE and clear gnt0, gnt1, rd_valid, rd_id, busy and cur_addr (rom_addr=0) and remaining to 0.
REQ-029 On reset, the last-served pointer SHALL be set to 1, so requester 0 wins the first contested grant.
REQ-030 Reset during BURST SHALL abort the burst; rd_valid SHALL be 0 from the cycle after the reset edge and no further addresses advance.

Verification
All scenarios use a 16x8 ROM preloaded with rom[i]=8'hA0+i.
REQ-031 Single burst: req0=1, addr0=3, len0=2 -> one gnt0 pulse; rom_addr 3,4,5; rd_valid three cycles with rd_data A3,A4,A5 and rd_id=0.
REQ-032 Wrap-around: req1=1, addr1=14, len1=3 -> rd_data AE,AF,A0,A1 with rd_id=1.
REQ-033 Contention after reset: req0 and req1 high together -> gnt0 first; after that burst, gnt1 without req0 dropping; one idle rd_valid cycle between the bursts.
REQ-034 Full-depth burst: addr0=0, len0=15 -> 16 consecutive rd_valid cycles returning A0..AF.
REQ-035 Mid-burst reset: reset asserted in the 2nd address cycle of a len=7 burst -> rd_valid=0, busy=0, rom_addr=0 after the edge; a new req0 then completes normally.
REQ-036 Bench SHALL check in every cycle that gnt0 and gnt1 are mutually exclusive and absent while busy is high.

Source files
------------

// File: rtl/rom_burst_arbiter_if.sv
// rom_burst_arbiter_if
//   Bundles the two requester ports, the ROM address/data pair and the
//   read-return signals of rom_burst_arbiter.
//
//   Requester side : req0/req1, addr0/addr1, len0/len1 (in), gnt0/gnt1 (out)
//   ROM side       : rom_addr (out), rom_data (in, valid one cycle after rom_addr)
//   Return side    : rd_data, rd_valid, rd_id (out)
//   Status         : busy (out, high in BURST), dbg_state (out, raw FSM state)
//
//   Handshake: a requester raises reqN with addrN/lenN and holds all three
//   stable until it sees gntN high for one cycle. The arbiter samples them
//   only in the IDLE cycle that produces the grant; gntN appears the cycle
//   after that sampling edge, and the burst words follow on rd_valid/rd_id.
//   There is no back-pressure on the return path.
//
//   Modports: slave = the arbiter, master = the requester/ROM environment.

interface rom_burst_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 4
);
  logic                 req0;
  logic                 req1;
  logic [LOG_DEPTH-1:0] addr0;
  logic [LOG_DEPTH-1:0] addr1;
  logic [LOG_DEPTH-1:0] len0;
  logic [LOG_DEPTH-1:0] len1;
  logic                 gnt0;
  logic                 gnt1;
  logic [LOG_DEPTH-1:0] rom_addr;
  logic [WIDTH-1:0]     rom_data;
  logic [WIDTH-1:0]     rd_data;
  logic                 rd_valid;
  logic                 rd_id;
  logic                 busy;
  logic                 dbg_state;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, rom_data,
    output gnt0, gnt1, rom_addr, rd_data, rd_valid, rd_id, busy, dbg_state
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, rom_data,
    input  gnt0, gnt1, rom_addr, rd_data, rd_valid, rd_id, busy, dbg_state
  );
endinterface

// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
//   Two-requester round-robin arbiter in front of a registered-output ROM.
//   A granted requester gets len+1 consecutive words starting at its start
//   address; the address counter wraps modulo DEPTH.
//
//   Ports:
//     clk    - single clock, everything changes on its rising edge
//     reset  - synchronous, active-high
//     bus    - rom_burst_arbiter_if.slave (requesters, ROM, read return,
//              busy and dbg_state)
//
//   Timing for a grant registered at the edge ending cycle T:
//     gntN high in T+1, addresses issued in T+1 .. T+1+len,
//     rd_valid high in T+2 .. T+2+len, FSM back in IDLE from T+2+len so the
//     next grant can be registered at the end of that cycle, leaving one
//     rd_valid-low cycle between back-to-back bursts.

module rom_burst_arbiter #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  rom_burst_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state;
  logic [LOG_DEPTH-1:0] cur_addr;
  logic [LOG_DEPTH-1:0] remaining;
  logic                 owner;
  logic                 last_served;
  logic                 gnt0_q;
  logic                 gnt1_q;
  logic                 rd_valid_q;
  logic                 rd_id_q;

  logic                 any_req;
  logic                 pick;
  logic [LOG_DEPTH-1:0] next_addr;
  logic [WIDTH-1:0]     rd_word;

  // Round-robin choice: under contention the requester not served last
  // wins; a lone requester wins regardless of history.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    pick    = 1'b0;
    if (bus.req0 && bus.req1) begin
      pick = ~last_served;
    end else begin
      pick = bus.req1;
    end
  end

  // Explicit wrap so a non-power-of-two DEPTH still counts modulo DEPTH.
  always_comb begin
    next_addr = cur_addr + LOG_DEPTH'(1);
    if (cur_addr == LOG_DEPTH'(DEPTH - 1)) begin
      next_addr = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      owner       <= 1'b0;
      // Pointing at requester 1 lets requester 0 win the first contest.
      last_served <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_id_q     <= 1'b0;
    end else begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      // The ROM returns data one cycle after the address, so the return
      // qualifiers are the issue-cycle state and owner delayed by one.
      rd_valid_q <= (state == BURST);
      rd_id_q    <= owner;

      case (state)
        IDLE: begin
          if (any_req) begin
            if (pick) begin
              gnt1_q    <= 1'b1;
              cur_addr  <= bus.addr1;
              remaining <= bus.len1;
            end else begin
              gnt0_q    <= 1'b1;
              cur_addr  <= bus.addr0;
              remaining <= bus.len0;
            end
            owner       <= pick;
            last_served <= pick;
            state       <= BURST;
          end
        end

        BURST: begin
          // The last address stays on rom_addr through IDLE, so the counter
          // does not advance past it.
          if (remaining == '0) begin
            state <= IDLE;
          end else begin
            cur_addr  <= next_addr;
            remaining <= remaining - LOG_DEPTH'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rd_word       = bus.rom_data;
  assign bus.rd_data   = rd_word;
  assign bus.rom_addr  = cur_addr;
  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_id     = rd_id_q;
  assign bus.busy      = (state == BURST);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb_rom_burst_arbiter
//   Directed bench for rom_burst_arbiter with a 16x8 registered ROM holding
//   rom[i] = 8'hA0 + i. Inputs change and outputs are sampled 1 ns after
//   the rising edge; a negedge monitor watches the grant rules each cycle.

module tb_rom_burst_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic prev_busy;
  logic [7:0] rom [16];
  logic [7:0] exp_q [$];

  rom_burst_arbiter_if #(.WIDTH(8), .LOG_DEPTH(4)) bus ();

  rom_burst_arbiter #(.WIDTH(8), .DEPTH(16), .LOG_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset / ROM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'hA0 + 8'(i);
  end

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- per-cycle grant monitor ----------------
  // A grant is only legal in the first BURST cycle, i.e. decided from IDLE.
  initial prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (bus.gnt0 && bus.gnt1) begin
        failures++;
        $display("FAIL gnt_exclusive: gnt0=%b gnt1=%b expected not both", bus.gnt0, bus.gnt1);
      end
      checks++;
      if ((bus.gnt0 || bus.gnt1) && !(bus.busy && !prev_busy)) begin
        failures++;
        $display("FAIL gnt_in_burst: gnt0=%b gnt1=%b busy=%b prev_busy=%b expected grant only on BURST entry",
                 bus.gnt0, bus.gnt1, bus.busy, prev_busy);
      end
    end
    prev_busy = bus.busy;
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.addr0 = 4'd0;
    bus.addr1 = 4'd0;
    bus.len0  = 4'd0;
    bus.len1  = 4'd0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0: got %b expected 0", bus.gnt0); end
    checks++; if (bus.gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1: got %b expected 0", bus.gnt1); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rd_id !== 1'b0) begin failures++; $display("FAIL reset_rd_id: got %b expected 0", bus.rd_id); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rom_addr !== 4'd0) begin failures++; $display("FAIL reset_rom_addr: got %0d expected 0", bus.rom_addr); end
    reset = 1'b0;
  endtask

  // Both request right after reset: 0 first, then 1 while req0 stays high.
  task automatic test_contention();
    bus.req0 = 1'b1; bus.addr0 = 4'd2; bus.len0 = 4'd1;
    bus.req1 = 1'b1; bus.addr1 = 4'd9; bus.len1 = 4'd2;
    tick();
    checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL cont_first_gnt0: got %b expected 1", bus.gnt0); end
    checks++; if (bus.gnt1 !== 1'b0) begin failures++; $display("FAIL cont_first_gnt1: got %b expected 0", bus.gnt1); end
    checks++; if (bus.rom_addr !== 4'd2) begin failures++; $display("FAIL cont_first_addr: got %0d expected 2", bus.rom_addr); end
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    for (int k = 0; k < 2; k++) begin
      logic [7:0] e;
      tick();
      e = exp_q.pop_front();
      checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL cont_b0_valid[%0d]: got %b expected 1", k, bus.rd_valid); end
      checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL cont_b0_data[%0d]: got %h expected %h", k, bus.rd_data, e); end
      checks++; if (bus.rd_id !== 1'b0) begin failures++; $display("FAIL cont_b0_id[%0d]: got %b expected 0", k, bus.rd_id); end
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cont_b0_end_busy: got %b expected 0", bus.busy); end
    tick();
    checks++; if (bus.gnt1 !== 1'b1) begin failures++; $display("FAIL cont_second_gnt1: got %b expected 1", bus.gnt1); end
    checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL cont_second_gnt0: got %b expected 0", bus.gnt0); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL cont_gap_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rom_addr !== 4'd9) begin failures++; $display("FAIL cont_second_addr: got %0d expected 9", bus.rom_addr); end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    exp_q.push_back(8'hA9);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hAB);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] e;
      tick();
      e = exp_q.pop_front();
      checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL cont_b1_valid[%0d]: got %b expected 1", k, bus.rd_valid); end
      checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL cont_b1_data[%0d]: got %h expected %h", k, bus.rd_data, e); end
      checks++; if (bus.rd_id !== 1'b1) begin failures++; $display("FAIL cont_b1_id[%0d]: got %b expected 1", k, bus.rd_id); end
    end
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL cont_tail_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cont_tail_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_single();
    logic [3:0] addr_exp [3];
    addr_exp[0] = 4'd4; addr_exp[1] = 4'd5; addr_exp[2] = 4'd5;
    bus.req0 = 1'b1; bus.addr0 = 4'd3; bus.len0 = 4'd2;
    tick();
    checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL single_gnt0: got %b expected 1", bus.gnt0); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.rom_addr !== 4'd3) begin failures++; $display("FAIL single_addr0: got %0d expected 3", bus.rom_addr); end
    bus.req0 = 1'b0;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA4);
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] e;
      tick();
      e = exp_q.pop_front();
      checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL single_gnt_pulse[%0d]: got %b expected 0", k, bus.gnt0); end
      checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d]: got %b expected 1", k, bus.rd_valid); end
      checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL single_data[%0d]: got %h expected %h", k, bus.rd_data, e); end
      checks++; if (bus.rd_id !== 1'b0) begin failures++; $display("FAIL single_id[%0d]: got %b expected 0", k, bus.rd_id); end
      checks++; if (bus.rom_addr !== addr_exp[k]) begin failures++; $display("FAIL single_rom_addr[%0d]: got %0d expected %0d", k, bus.rom_addr, addr_exp[k]); end
    end
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL single_tail_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rom_addr !== 4'd5) begin failures++; $display("FAIL single_hold_addr: got %0d expected 5", bus.rom_addr); end
  endtask

  task automatic test_wrap();
    logic [3:0] addr_exp [4];
    addr_exp[0] = 4'd15; addr_exp[1] = 4'd0; addr_exp[2] = 4'd1; addr_exp[3] = 4'd1;
    bus.req1 = 1'b1; bus.addr1 = 4'd14; bus.len1 = 4'd3;
    tick();
    checks++; if (bus.gnt1 !== 1'b1) begin failures++; $display("FAIL wrap_gnt1: got %b expected 1", bus.gnt1); end
    checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL wrap_gnt0: got %b expected 0", bus.gnt0); end
    checks++; if (bus.rom_addr !== 4'd14) begin failures++; $display("FAIL wrap_addr0: got %0d expected 14", bus.rom_addr); end
    bus.req1 = 1'b0;
    exp_q.push_back(8'hAE);
    exp_q.push_back(8'hAF);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e;
      tick();
      e = exp_q.pop_front();
      checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid[%0d]: got %b expected 1", k, bus.rd_valid); end
      checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL wrap_data[%0d]: got %h expected %h", k, bus.rd_data, e); end
      checks++; if (bus.rd_id !== 1'b1) begin failures++; $display("FAIL wrap_id[%0d]: got %b expected 1", k, bus.rd_id); end
      checks++; if (bus.rom_addr !== addr_exp[k]) begin failures++; $display("FAIL wrap_rom_addr[%0d]: got %0d expected %0d", k, bus.rom_addr, addr_exp[k]); end
    end
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL wrap_tail_valid: got %b expected 0", bus.rd_valid); end
  endtask

  task automatic test_full_depth();
    bus.req0 = 1'b1; bus.addr0 = 4'd0; bus.len0 = 4'd15;
    tick();
    checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL full_gnt0: got %b expected 1", bus.gnt0); end
    bus.req0 = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back(8'hA0 + 8'(k));
    for (int k = 0; k < 16; k++) begin
      logic [7:0] e;
      logic       busy_exp;
      tick();
      e = exp_q.pop_front();
      busy_exp = (k < 15);
      checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL full_valid[%0d]: got %b expected 1", k, bus.rd_valid); end
      checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL full_data[%0d]: got %h expected %h", k, bus.rd_data, e); end
      checks++; if (bus.rd_id !== 1'b0) begin failures++; $display("FAIL full_id[%0d]: got %b expected 0", k, bus.rd_id); end
      checks++; if (bus.busy !== busy_exp) begin failures++; $display("FAIL full_busy[%0d]: got %b expected %b", k, bus.busy, busy_exp); end
    end
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL full_tail_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rom_addr !== 4'd15) begin failures++; $display("FAIL full_hold_addr: got %0d expected 15", bus.rom_addr); end
  endtask

  task automatic test_midburst_reset();
    bus.req0 = 1'b1; bus.addr0 = 4'd5; bus.len0 = 4'd7;
    tick();
    checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL mid_gnt0: got %b expected 1", bus.gnt0); end
    bus.req0 = 1'b0;
    tick();
    checks++; if (bus.rom_addr !== 4'd6) begin failures++; $display("FAIL mid_second_addr: got %0d expected 6", bus.rom_addr); end
    checks++; if (bus.rd_data !== 8'hA5) begin failures++; $display("FAIL mid_first_data: got %h expected a5", bus.rd_data); end
    reset = 1'b1;
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rom_addr !== 4'd0) begin failures++; $display("FAIL mid_rst_addr: got %0d expected 0", bus.rom_addr); end
    reset = 1'b0;
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL mid_post_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rom_addr !== 4'd0) begin failures++; $display("FAIL mid_post_addr: got %0d expected 0", bus.rom_addr); end
    bus.req0 = 1'b1; bus.addr0 = 4'd1; bus.len0 = 4'd1;
    tick();
    checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL mid_new_gnt0: got %b expected 1", bus.gnt0); end
    checks++; if (bus.rom_addr !== 4'd1) begin failures++; $display("FAIL mid_new_addr: got %0d expected 1", bus.rom_addr); end
    bus.req0 = 1'b0;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    for (int k = 0; k < 2; k++) begin
      logic [7:0] e;
      tick();
      e = exp_q.pop_front();
      checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL mid_new_valid[%0d]: got %b expected 1", k, bus.rd_valid); end
      checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL mid_new_data[%0d]: got %h expected %h", k, bus.rd_data, e); end
      checks++; if (bus.rd_id !== 1'b0) begin failures++; $display("FAIL mid_new_id[%0d]: got %b expected 0", k, bus.rd_id); end
    end
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL mid_new_tail: got %b expected 0", bus.rd_valid); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_contention();
    test_single();
    test_wrap();
    test_full_depth();
    test_midburst_reset();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
